// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoder-side inputs, forwarding taps and ALU-side outputs.
// No logic; signal bundle only.
// master drives the stage inputs, slave is the stage itself.
interface id_ex_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          in_valid_i;
  logic          in_ready_o;
  logic [2:0]    alu_op_i;
  logic [5:0]    funct_i;
  logic [DW-1:0] rs_data_i;
  logic [DW-1:0] rt_data_i;
  logic [15:0]   imm_i;
  logic [RW-1:0] rs_addr_i;
  logic [RW-1:0] rt_addr_i;
  logic [RW-1:0] rd_addr_i;
  logic          alu_src_i;
  logic          reg_dst_i;
  logic          reg_write_i;
  logic          flush_i;
  logic          exmem_reg_write_i;
  logic [RW-1:0] exmem_rd_i;
  logic [DW-1:0] exmem_data_i;
  logic          memwb_reg_write_i;
  logic [RW-1:0] memwb_rd_i;
  logic [DW-1:0] memwb_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] alu_src1_o;
  logic [DW-1:0] alu_src2_o;
  logic [3:0]    alu_ctrl_o;
  logic [DW-1:0] store_data_o;
  logic [RW-1:0] wr_addr_o;
  logic          reg_write_o;
  logic          illegal_o;

  modport master (
    output in_valid_i, alu_op_i, funct_i, rs_data_i, rt_data_i, imm_i,
           rs_addr_i, rt_addr_i, rd_addr_i, alu_src_i, reg_dst_i, reg_write_i,
           flush_i, exmem_reg_write_i, exmem_rd_i, exmem_data_i,
           memwb_reg_write_i, memwb_rd_i, memwb_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
           store_data_o, wr_addr_o, reg_write_o, illegal_o
  );

  modport slave (
    input  in_valid_i, alu_op_i, funct_i, rs_data_i, rt_data_i, imm_i,
           rs_addr_i, rt_addr_i, rd_addr_i, alu_src_i, reg_dst_i, reg_write_i,
           flush_i, exmem_reg_write_i, exmem_rd_i, exmem_data_i,
           memwb_reg_write_i, memwb_rd_i, memwb_data_i, out_ready_i,
    output in_ready_o, out_valid_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
           store_data_o, wr_addr_o, reg_write_o, illegal_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode and EX/MEM, MEM/WB forwarding.
// Latency: 1 cycle from accepted input to out_valid_o; forwarding muxes are combinational.
// Backpressure: in_ready_o = !out_valid_o | out_ready_i; contents hold while stalled.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  id_ex_stage_if.slave  bus
);

  logic          vld_q;
  logic [3:0]    ctrl_q;
  logic          illegal_q;
  logic          reg_write_q;
  logic [RW-1:0] wr_addr_q;
  logic [RW-1:0] rs_addr_q;
  logic [RW-1:0] rt_addr_q;
  logic [DW-1:0] rs_data_q;
  logic [DW-1:0] rt_data_q;
  logic [DW-1:0] imm_q;
  logic          alu_src_q;

  logic          load;
  logic [3:0]    ctrl_d;
  logic          illegal_d;
  logic [DW-1:0] imm_d;
  logic [RW-1:0] wr_addr_d;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  assign bus.in_ready_o = !vld_q || bus.out_ready_i;
  assign load           = bus.in_valid_i && bus.in_ready_o;

  // Decode ALU control from ALUOp class and funct; unknown encodings flag illegal.
  always_comb begin
    ctrl_d    = 4'b0010;
    illegal_d = 1'b0;
    unique case (bus.alu_op_i)
      3'b000: ctrl_d = 4'b0010;
      3'b001: ctrl_d = 4'b0110;
      3'b011: ctrl_d = 4'b0111;
      3'b100: ctrl_d = 4'b0001;
      3'b101: ctrl_d = 4'b0000;
      3'b010: begin
        unique case (bus.funct_i)
          6'b100000: ctrl_d = 4'b0010;
          6'b100010: ctrl_d = 4'b0110;
          6'b100100: ctrl_d = 4'b0000;
          6'b100101: ctrl_d = 4'b0001;
          6'b101010: ctrl_d = 4'b0111;
          6'b100111: ctrl_d = 4'b1100;
          default:   illegal_d = 1'b1;
        endcase
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // Logical immediates (ori/andi) zero-extend, everything else sign-extends.
  always_comb begin
    if (bus.alu_op_i == 3'b100 || bus.alu_op_i == 3'b101)
      imm_d = {{(DW-16){1'b0}}, bus.imm_i};
    else
      imm_d = {{(DW-16){bus.imm_i[15]}}, bus.imm_i};
  end

  assign wr_addr_d = bus.reg_dst_i ? bus.rd_addr_i : bus.rt_addr_i;

  // Pipeline register: reset > flush > load > drain/hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q       <= 1'b0;
      ctrl_q      <= 4'b0010;
      illegal_q   <= 1'b0;
      reg_write_q <= 1'b0;
      wr_addr_q   <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
    end else if (bus.flush_i) begin
      vld_q <= 1'b0;
    end else if (load) begin
      vld_q       <= 1'b1;
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
      reg_write_q <= bus.reg_write_i && !illegal_d && (wr_addr_d != '0);
      wr_addr_q   <= wr_addr_d;
      rs_addr_q   <= bus.rs_addr_i;
      rt_addr_q   <= bus.rt_addr_i;
      rs_data_q   <= bus.rs_data_i;
      rt_data_q   <= bus.rt_data_i;
      imm_q       <= imm_d;
      alu_src_q   <= bus.alu_src_i;
    end else if (bus.out_ready_i) begin
      vld_q <= 1'b0;
    end
  end

  // Per-operand forwarding: the younger EX/MEM result wins over MEM/WB; $0 never forwards.
  always_comb begin
    fwd_rs = rs_data_q;
    if (bus.exmem_reg_write_i && bus.exmem_rd_i != '0 && bus.exmem_rd_i == rs_addr_q)
      fwd_rs = bus.exmem_data_i;
    else if (bus.memwb_reg_write_i && bus.memwb_rd_i != '0 && bus.memwb_rd_i == rs_addr_q)
      fwd_rs = bus.memwb_data_i;

    fwd_rt = rt_data_q;
    if (bus.exmem_reg_write_i && bus.exmem_rd_i != '0 && bus.exmem_rd_i == rt_addr_q)
      fwd_rt = bus.exmem_data_i;
    else if (bus.memwb_reg_write_i && bus.memwb_rd_i != '0 && bus.memwb_rd_i == rt_addr_q)
      fwd_rt = bus.memwb_data_i;
  end

  assign bus.out_valid_o  = vld_q;
  assign bus.alu_ctrl_o   = ctrl_q;
  assign bus.illegal_o    = illegal_q;
  assign bus.reg_write_o  = reg_write_q;
  assign bus.wr_addr_o    = wr_addr_q;
  assign bus.alu_src1_o   = fwd_rs;
  assign bus.store_data_o = fwd_rt;
  assign bus.alu_src2_o   = alu_src_q ? imm_q : fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, immediates, stall, forwarding, flush, illegal.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Expected values are hand-computed constants.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DW(32), .RW(5)) bus ();

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [31:0] rsd,
                       input logic [4:0] rt, input logic [31:0] rtd,
                       input logic [4:0] rd, input logic [15:0] imm,
                       input logic asrc, input logic rdst);
    bus.alu_op_i    = op;
    bus.funct_i     = fn;
    bus.rs_addr_i   = rs;
    bus.rs_data_i   = rsd;
    bus.rt_addr_i   = rt;
    bus.rt_data_i   = rtd;
    bus.rd_addr_i   = rd;
    bus.imm_i       = imm;
    bus.alu_src_i   = asrc;
    bus.reg_dst_i   = rdst;
    bus.reg_write_i = 1'b1;
  endtask

  initial begin
    bus.in_valid_i        = 1'b0;
    bus.out_ready_i       = 1'b1;
    bus.flush_i           = 1'b0;
    bus.exmem_reg_write_i = 1'b0;
    bus.exmem_rd_i        = '0;
    bus.exmem_data_i      = '0;
    bus.memwb_reg_write_i = 1'b0;
    bus.memwb_rd_i        = '0;
    bus.memwb_data_i      = '0;
    drive(3'b000, 6'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 16'd0, 1'b0, 1'b0);
    bus.reg_write_i = 1'b0;

    // Reset state
    step();
    step();
    check("rst_valid", {31'd0, bus.out_valid_o}, 32'd0);
    check("rst_rw",    {31'd0, bus.reg_write_o}, 32'd0);
    check("rst_ill",   {31'd0, bus.illegal_o}, 32'd0);
    check("rst_wr",    {27'd0, bus.wr_addr_o}, 32'd0);
    check("rst_ctrl",  {28'd0, bus.alu_ctrl_o}, 32'h2);
    check("rst_src1",  bus.alu_src1_o, 32'd0);
    check("rst_src2",  bus.alu_src2_o, 32'd0);
    check("rst_rdy",   {31'd0, bus.in_ready_o}, 32'd1);
    rst = 1'b0;

    // R-type add
    drive(3'b010, 6'b100000, 5'd3, 32'd5, 5'd4, 32'd7, 5'd9, 16'd0, 1'b0, 1'b1);
    bus.in_valid_i = 1'b1;
    step();
    check("add_valid", {31'd0, bus.out_valid_o}, 32'd1);
    check("add_ctrl",  {28'd0, bus.alu_ctrl_o}, 32'h2);
    check("add_src1",  bus.alu_src1_o, 32'd5);
    check("add_src2",  bus.alu_src2_o, 32'd7);
    check("add_store", bus.store_data_o, 32'd7);
    check("add_wr",    {27'd0, bus.wr_addr_o}, 32'd9);
    check("add_rw",    {31'd0, bus.reg_write_o}, 32'd1);
    check("add_ill",   {31'd0, bus.illegal_o}, 32'd0);

    // ori zero-extends, destination is rt
    drive(3'b100, 6'd0, 5'd3, 32'd5, 5'd4, 32'd7, 5'd9, 16'h8001, 1'b1, 1'b0);
    step();
    check("ori_src2", bus.alu_src2_o, 32'h0000_8001);
    check("ori_ctrl", {28'd0, bus.alu_ctrl_o}, 32'h1);
    check("ori_wr",   {27'd0, bus.wr_addr_o}, 32'd4);

    // addi sign-extends
    drive(3'b000, 6'd0, 5'd3, 32'd5, 5'd4, 32'd7, 5'd9, 16'h8001, 1'b1, 1'b0);
    step();
    check("addi_src2", bus.alu_src2_o, 32'hFFFF_8001);
    check("addi_ctrl", {28'd0, bus.alu_ctrl_o}, 32'h2);

    // Stall three cycles with a pending sub
    bus.out_ready_i = 1'b0;
    drive(3'b010, 6'b100010, 5'd1, 32'd11, 5'd2, 32'd22, 5'd5, 16'd0, 1'b0, 1'b1);
    #1;
    check("stall_rdy0", {31'd0, bus.in_ready_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_rdy",   {31'd0, bus.in_ready_o}, 32'd0);
      check("stall_valid", {31'd0, bus.out_valid_o}, 32'd1);
      check("stall_src2",  bus.alu_src2_o, 32'hFFFF_8001);
      check("stall_ctrl",  {28'd0, bus.alu_ctrl_o}, 32'h2);
    end
    bus.out_ready_i = 1'b1;
    #1;
    check("unstall_rdy", {31'd0, bus.in_ready_o}, 32'd1);
    step();
    check("sub_ctrl",  {28'd0, bus.alu_ctrl_o}, 32'h6);
    check("sub_src1",  bus.alu_src1_o, 32'd11);
    check("sub_src2",  bus.alu_src2_o, 32'd22);
    check("sub_wr",    {27'd0, bus.wr_addr_o}, 32'd5);
    check("sub_valid", {31'd0, bus.out_valid_o}, 32'd1);

    // Forwarding priority on a held instruction rs=6, rt=7
    drive(3'b010, 6'b100000, 5'd6, 32'h11, 5'd7, 32'h22, 5'd8, 16'd0, 1'b0, 1'b1);
    step();
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    check("fwd_none", bus.alu_src1_o, 32'h11);
    bus.exmem_reg_write_i = 1'b1; bus.exmem_rd_i = 5'd6; bus.exmem_data_i = 32'hAA;
    bus.memwb_reg_write_i = 1'b1; bus.memwb_rd_i = 5'd6; bus.memwb_data_i = 32'hBB;
    #1;
    check("fwd_exmem", bus.alu_src1_o, 32'hAA);
    check("fwd_rt_miss", bus.store_data_o, 32'h22);
    bus.exmem_reg_write_i = 1'b0;
    #1;
    check("fwd_memwb", bus.alu_src1_o, 32'hBB);
    bus.memwb_rd_i = 5'd7; bus.memwb_data_i = 32'hCC;
    #1;
    check("fwd_rt_store", bus.store_data_o, 32'hCC);
    check("fwd_rt_src2",  bus.alu_src2_o, 32'hCC);
    check("fwd_rs_back",  bus.alu_src1_o, 32'h11);

    // rs=$0 never forwards
    bus.exmem_reg_write_i = 1'b0; bus.memwb_reg_write_i = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    drive(3'b010, 6'b100000, 5'd0, 32'h33, 5'd7, 32'h22, 5'd8, 16'd0, 1'b0, 1'b1);
    step();
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.exmem_reg_write_i = 1'b1; bus.exmem_rd_i = 5'd0; bus.exmem_data_i = 32'hAA;
    bus.memwb_reg_write_i = 1'b1; bus.memwb_rd_i = 5'd0; bus.memwb_data_i = 32'hBB;
    #1;
    check("fwd_zero", bus.alu_src1_o, 32'h33);
    bus.exmem_reg_write_i = 1'b0; bus.memwb_reg_write_i = 1'b0;

    // Flush coincident with a valid load
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.flush_i     = 1'b1;
    drive(3'b101, 6'd0, 5'd1, 32'h44, 5'd2, 32'h55, 5'd12, 16'h1234, 1'b1, 1'b1);
    step();
    bus.flush_i = 1'b0;
    check("flush_valid", {31'd0, bus.out_valid_o}, 32'd0);
    check("flush_wr",    {27'd0, bus.wr_addr_o}, 32'd8);
    check("flush_ctrl",  {28'd0, bus.alu_ctrl_o}, 32'h2);
    check("flush_src1",  bus.alu_src1_o, 32'h33);

    // Illegal funct
    drive(3'b010, 6'b000111, 5'd1, 32'h44, 5'd2, 32'h55, 5'd9, 16'd0, 1'b0, 1'b1);
    step();
    check("ill_valid", {31'd0, bus.out_valid_o}, 32'd1);
    check("ill_flag",  {31'd0, bus.illegal_o}, 32'd1);
    check("ill_rw",    {31'd0, bus.reg_write_o}, 32'd0);
    check("ill_ctrl",  {28'd0, bus.alu_ctrl_o}, 32'h2);

    // nor decodes to 1100
    drive(3'b010, 6'b100111, 5'd1, 32'h44, 5'd2, 32'h55, 5'd9, 16'd0, 1'b0, 1'b1);
    step();
    check("nor_ctrl", {28'd0, bus.alu_ctrl_o}, 32'hC);
    check("nor_ill",  {31'd0, bus.illegal_o}, 32'd0);

    // Valid add targeting $0
    drive(3'b010, 6'b100000, 5'd1, 32'h44, 5'd2, 32'h55, 5'd0, 16'd0, 1'b0, 1'b1);
    step();
    check("r0_rw",  {31'd0, bus.reg_write_o}, 32'd0);
    check("r0_ill", {31'd0, bus.illegal_o}, 32'd0);

    // Drain: consumed with no new load
    bus.in_valid_i = 1'b0;
    step();
    check("drain_valid", {31'd0, bus.out_valid_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between the instruction decoder and the 32-bit ALU.
- Captures decoded operands and control under a valid/ready handshake, and generates the 4-bit ALU control code.
- Resolves EX/MEM and MEM/WB forwarding, then presents final src1/src2 to the ALU.
- Supports downstream stall and synchronous flush for branch redirects.

Parameters:
- DW, 32, datapath width
- RW, 5, register-address width

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- in_valid_i  in  1  decoder has an instruction
- in_ready_o  out  1  stage can accept
- alu_op_i  in  3  decoder ALUOp class
- funct_i  in  6  R-type funct field
- rs_data_i  in  DW  register-file read data A
- rt_data_i  in  DW  register-file read data B
- imm_i  in  16  instruction immediate
- rs_addr_i  in  RW  source register A
- rt_addr_i  in  RW  source register B
- rd_addr_i  in  RW  R-type destination
- alu_src_i  in  1  1 = use immediate as src2
- reg_dst_i  in  1  1 = destination is rd, 0 = rt
- reg_write_i  in  1  instruction writes the register file
- flush_i  in  1  kill held and incoming instruction
- exmem_reg_write_i  in  1  EX/MEM forwarding source valid
- exmem_rd_i  in  RW  EX/MEM destination
- exmem_data_i  in  DW  EX/MEM result
- memwb_reg_write_i  in  1  MEM/WB forwarding source valid
- memwb_rd_i  in  RW  MEM/WB destination
- memwb_data_i  in  DW  MEM/WB result
- out_valid_o  out  1  held instruction valid
- out_ready_i  in  1  EX stage consumes
- alu_src1_o  out  DW  to ALU src1
- alu_src2_o  out  DW  to ALU src2
- alu_ctrl_o  out  4  to ALU ctrl
- store_data_o  out  DW  forwarded rt value
- wr_addr_o  out  RW  selected destination
- reg_write_o  out  1  registered write enable (gated)
- illegal_o  out  1  held instruction had undecodable op

Behaviour:
- Reset (rst_i=1 at edge) clears every register.
  - Outputs become: out_valid_o=0, reg_write_o=0, illegal_o=0, wr_addr_o=0, alu_ctrl_o=4'b0010.
  - Data outputs become 0 when forwarding misses.
  - Reset overrides flush and load.
- Handshake:
  - in_ready_o = !out_valid_o | out_ready_i (combinational).
  - Load occurs when in_valid_i & in_ready_o. Latency is 1 cycle: load at edge N, out_valid_o=1 after edge N.
  - Held contents are stable while out_valid_o & !out_ready_i.
  - If out_ready_i=1 and there is no load, out_valid_o clears.
- Flush:
  - flush_i=1 at an edge sets out_valid_o=0 and discards any simultaneous load.
  - Flush priority: reset > flush > load > hold.
- ALU control decode is performed at load and registered:
  - ALUOp 000 (lw/sw/addi) -> 0010
  - ALUOp 001 (beq) -> 0110
  - ALUOp 011 (slti) -> 0111
  - ALUOp 100 (ori) -> 0001
  - ALUOp 101 (andi) -> 0000
  - ALUOp 010 (R-type), by funct:
    - 100000 -> 0010
    - 100010 -> 0110
    - 100100 -> 0000
    - 100101 -> 0001
    - 101010 -> 0111
    - 100111 -> 1100
  - Any other ALUOp/funct: alu_ctrl=0010, illegal_o=1, reg_write_o=0.
- Immediate extension: zero-extend for ALUOp 100/101, sign-extend otherwise.
- Destination: wr_addr_o = reg_dst ? rd : rt.
- reg_write_o is additionally forced 0 when wr_addr_o==0.
- Forwarding is combinational on the registered rs/rt and live bus inputs, evaluated per operand:
  - EX/MEM hit: exmem_reg_write_i & exmem_rd_i!=0 & exmem_rd_i==addr.
  - Otherwise MEM/WB hit, same condition.
  - Otherwise the registered value.
  - EX/MEM wins when both hit.
- Operand outputs:
  - alu_src1_o = forwarded rs.
  - store_data_o = forwarded rt.
  - alu_src2_o = alu_src ? extended imm : forwarded rt.
- Forwarding results are meaningful only when out_valid_o=1. Outputs are not gated to 0 when invalid.

Test Plan:
- Reset, then R-type add:
  - Stimulus: funct 100000, rs=3 data 5, rt=4 data 7, rd=9.
  - Required: one cycle later out_valid_o=1, alu_ctrl_o=0010, src1=5, src2=7, wr_addr_o=9, reg_write_o=1.
- Immediate extension:
  - ori with imm 16'h8001 -> src2=32'h00008001, ctrl 0001.
  - addi with imm 16'h8001 -> src2=32'hFFFF8001, ctrl 0010.
- Stall:
  - Stimulus: out_ready_i=0 for 3 cycles with in_valid_i=1.
  - Required: in_ready_o=0, outputs unchanged. On out_ready_i=1 the next instruction loads in the same edge.
- Forwarding priority:
  - Stimulus: rs=6 held; exmem rd=6 data 0xAA; memwb rd=6 data 0xBB, both write.
  - Required: src1=0xAA. Dropping exmem_reg_write_i -> 0xBB. With rs=0 -> register value regardless.
- Flush:
  - Stimulus: flush_i=1 coincident with a valid load.
  - Required: out_valid_o=0 next cycle, new instruction discarded.
- Illegal and $0 cases:
  - funct 000111 -> illegal_o=1, reg_write_o=0, alu_ctrl_o=0010.
  - Valid add with rd=0 -> reg_write_o=0.
